// File: rtl/rtmq_cfg_loader_pkg.sv
// Shared constants and issue-FSM encoding for the RTMQ configuration loader
// and its host-link peripherals.
package rtmq_cfg_loader_pkg;

  localparam int W_REG_DEF   = 32;
  localparam int RTMQ_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } iss_st_e;

  // Counter width that stays legal for single-value ranges.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/rtmq_cfg_loader_fifo.sv
// Synchronous word FIFO with show-ahead head output; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module rtmq_sync_fifo #(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [W-1:0]         din,
  output logic [W-1:0]         dout,
  output logic [$clog2(N):0]   cnt,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N) + 1;

  logic [W-1:0]  mem_q [N];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == CW'(N));
  assign empty = (cnt_q == '0);
  assign cnt   = cnt_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/rtmq_cfg_loader.sv
// Host byte stream -> big-endian config words -> FIFO -> paced f_cfg pulses
// into the RTMQ core configuration port.
module rtmq_cfg_loader
  import rtmq_cfg_loader_pkg::*;
#(
  parameter int W_REG  = W_REG_DEF,
  parameter int N_FIFO = 8,
  parameter int T_GAP  = 4,
  parameter int T_TOUT = 100000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                rx_dat,
  input  logic                      rx_vld,
  input  logic                      en,
  output logic [W_REG-1:0]          cfg_ins,
  output logic                      f_cfg,
  input  logic                      clr_err,
  output logic                      ovf,
  output logic                      frm_err,
  output logic [$clog2(N_FIFO):0]   fifo_cnt
);

  localparam int NB  = W_REG / RTMQ_BYTE_W;
  localparam int BCW = clog2_min1(NB);
  localparam int TMW = $clog2(T_TOUT + 1);
  localparam int GCW = clog2_min1(T_GAP);

  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d, base_cnt;
  logic [W_REG-1:0] sr_q, sr_d;
  logic [TMW-1:0]   tmr_q, tmr_d;
  logic             ovf_q, ovf_d, frm_err_q, frm_err_d;
  logic             tout, push, pop, drop;
  iss_st_e          state_q, state_d;
  logic [GCW-1:0]   gap_q, gap_d;
  logic             f_cfg_q, f_cfg_d;
  logic [W_REG-1:0] cfg_ins_q, cfg_ins_d;
  logic [W_REG-1:0] fifo_dout;
  logic             fifo_full, fifo_empty;

  // Byte assembly and inter-byte timeout. A byte landing in the timeout
  // cycle opens a fresh word rather than extending the stale one.
  always_comb begin
    tout     = (byte_cnt_q != '0) && (tmr_q == TMW'(T_TOUT));
    base_cnt = tout ? '0 : byte_cnt_q;
    push     = rx_vld && (base_cnt == BCW'(NB - 1));
    sr_d     = rx_vld ? ((sr_q << RTMQ_BYTE_W) | W_REG'(rx_dat)) : sr_q;
    byte_cnt_d = base_cnt;
    if (rx_vld) byte_cnt_d = push ? '0 : base_cnt + 1'b1;
    tmr_d = (rx_vld || tout || byte_cnt_q == '0) ? '0 : tmr_q + 1'b1;
    drop      = push && fifo_full && !pop;
    ovf_d     = drop | (ovf_q & ~clr_err);
    frm_err_d = tout | (frm_err_q & ~clr_err);
  end

  rtmq_sync_fifo #(.W(W_REG), .N(N_FIFO)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (sr_d),
    .dout  (fifo_dout),
    .cnt   (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE:  if (en && !fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: begin
        state_d = ST_GAP;
        gap_d   = '0;
      end
      ST_GAP: begin
        if (gap_q == GCW'(T_GAP - 1)) state_d = ST_IDLE;
        else                          gap_d   = gap_q + 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobe and word are registered, so they are live during ISSUE.
  always_comb begin
    pop       = (state_q == ST_IDLE) && en && !fifo_empty;
    f_cfg_d   = pop;
    cfg_ins_d = pop ? fifo_dout : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      sr_q       <= '0;
      tmr_q      <= '0;
      ovf_q      <= 1'b0;
      frm_err_q  <= 1'b0;
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      f_cfg_q    <= 1'b0;
      cfg_ins_q  <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      sr_q       <= sr_d;
      tmr_q      <= tmr_d;
      ovf_q      <= ovf_d;
      frm_err_q  <= frm_err_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      f_cfg_q    <= f_cfg_d;
      cfg_ins_q  <= cfg_ins_d;
    end
  end

  assign f_cfg   = f_cfg_q;
  assign cfg_ins = cfg_ins_q;
  assign ovf     = ovf_q;
  assign frm_err = frm_err_q;

endmodule

// File: tb/tb_rtmq_cfg_loader.sv
// Directed + random bench for rtmq_cfg_loader against a queue-based model.
module tb_rtmq_cfg_loader;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TG = 3;
  localparam int TT = 12;
  localparam int NB = W / 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [7:0]         rx_dat = '0;
  logic               rx_vld = 1'b0;
  logic               en = 1'b0;
  logic               clr_err = 1'b0;
  logic [W-1:0]       cfg_ins;
  logic               f_cfg, ovf, frm_err;
  logic [$clog2(N):0] fifo_cnt;

  always #5 clk = ~clk;

  rtmq_cfg_loader #(.W_REG(W), .N_FIFO(N), .T_GAP(TG), .T_TOUT(TT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_dat   (rx_dat),
    .rx_vld   (rx_vld),
    .en       (en),
    .cfg_ins  (cfg_ins),
    .f_cfg    (f_cfg),
    .clr_err  (clr_err),
    .ovf      (ovf),
    .frm_err  (frm_err),
    .fifo_cnt (fifo_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: word queue, pending bytes, idle run, issue hold-off.
  logic [W-1:0] mq[$];
  logic [7:0]   mb[$];
  int           m_idle, m_hold;
  bit           m_f, m_ovf, m_frm;
  logic [W-1:0] m_ins;

  logic [W-1:0] got[$];
  int           got_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete(); mb.delete();
    m_idle = 0; m_hold = 0;
    m_f = 0; m_ins = '0; m_ovf = 0; m_frm = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    bit pop, push, tout, drop;
    logic [W-1:0] w;
    w    = '0;
    push = 0;
    drop = 0;
    pop  = (m_hold == 0) && (en === 1'b1) && (mq.size() > 0);
    tout = (mb.size() > 0) && (m_idle == TT);
    if (tout) begin mb.delete(); m_idle = 0; end
    if (v) begin
      mb.push_back(d);
      m_idle = 0;
      if (mb.size() == NB) begin
        for (int i = 0; i < NB; i++) w = (w << 8) | W'(mb[i]);
        push = 1;
        mb.delete();
      end
    end else if (mb.size() > 0) m_idle++;
    m_f   = pop;
    m_ins = pop ? mq[0] : '0;
    if (pop) begin void'(mq.pop_front()); m_hold = TG + 1; end
    else if (m_hold > 0) m_hold--;
    if (push) begin
      if (mq.size() < N) mq.push_back(w);
      else drop = 1;
    end
    m_ovf = drop | (m_ovf & !clr_err);
    m_frm = tout | (m_frm & !clr_err);
  endtask

  // One clock cycle: check current outputs, apply inputs, advance model.
  task automatic step(input bit v, input logic [7:0] d);
    chk("f_cfg",    f_cfg,    m_f);
    chk("cfg_ins",  cfg_ins,  m_ins);
    chk("fifo_cnt", fifo_cnt, mq.size());
    chk("ovf",      ovf,      m_ovf);
    chk("frm_err",  frm_err,  m_frm);
    if (f_cfg === 1'b1) begin got.push_back(cfg_ins); got_cyc.push_back(cyc); end
    rx_vld = v; rx_dat = d;
    model_step(v, d);
    @(posedge clk); @(negedge clk);
    cyc++;
    rx_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit clr_last);
    for (int i = 0; i < NB; i++) begin
      if (clr_last && i == NB - 1) clr_err = 1'b1;
      step(1'b1, w[W-1-8*i -: 8]);
      clr_err = 1'b0;
    end
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_f_cfg",   f_cfg,    0);
    chk("rst_cfg_ins", cfg_ins,  0);
    chk("rst_cnt",     fifo_cnt, 0);
    chk("rst_ovf",     ovf,      0);
    chk("rst_frm",     frm_err,  0);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc++;
  endtask

  int n_last;

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Single word, latency 2 after the last byte.
    en = 1'b1;
    got.delete(); got_cyc.delete();
    send_word(32'h970185CA, 1'b0);
    n_last = cyc - 1;
    idle(8);
    chk("s1_count", got.size(), 1);
    if (got.size() == 1) begin
      chk("s1_word", got[0], 32'h970185CA);
      chk("s1_lat",  got_cyc[0], n_last + 2);
    end

    // Accumulate with en low, then drain in order with fixed spacing.
    en = 1'b0;
    got.delete(); got_cyc.delete();
    send_word(32'h11223344, 1'b0);
    send_word(32'h55667788, 1'b0);
    send_word(32'h99AABBCC, 1'b0);
    idle(2);
    chk("s2_cnt3", fifo_cnt, 3);
    en = 1'b1;
    idle(3 * (TG + 2) + 4);
    chk("s2_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("s2_w0", got[0], 32'h11223344);
      chk("s2_w1", got[1], 32'h55667788);
      chk("s2_w2", got[2], 32'h99AABBCC);
      // T_GAP+1 cycles between pulses, plus the pop cycle.
      chk("s2_sp0", got_cyc[1] - got_cyc[0], TG + 2);
      chk("s2_sp1", got_cyc[2] - got_cyc[1], TG + 2);
    end
    chk("s2_cnt0", fifo_cnt, 0);

    // Partial word timeout.
    got.delete(); got_cyc.delete();
    step(1'b1, 8'hAA);
    step(1'b1, 8'hBB);
    idle(TT);
    send_word(32'h01020304, 1'b0);
    idle(8);
    chk("s3_frm", frm_err, 1);
    chk("s3_count", got.size(), 1);
    if (got.size() == 1) chk("s3_word", got[0], 32'h01020304);
    clr_err = 1'b1; step(1'b0, 8'h00); clr_err = 1'b0;
    step(1'b0, 8'h00);
    chk("s3_clr", frm_err, 0);

    // Overflow: clr_err in the drop cycle loses to the set.
    en = 1'b0;
    got.delete(); got_cyc.delete();
    for (int i = 0; i < N; i++) send_word(32'hA0000000 + W'(i), 1'b0);
    send_word(32'hBEEF0000, 1'b1);
    idle(1);
    chk("s4_ovf", ovf, 1);
    chk("s4_cnt", fifo_cnt, N);
    en = 1'b1;
    idle((N + 1) * (TG + 2));
    chk("s4_count", got.size(), N);
    for (int i = 0; i < N; i++)
      if (i < got.size()) chk("s4_word", got[i], 32'hA0000000 + W'(i));
    clr_err = 1'b1; step(1'b0, 8'h00); clr_err = 1'b0;

    // Full FIFO, last byte arrives in the same cycle as a pop.
    en = 1'b0;
    got.delete(); got_cyc.delete();
    for (int i = 0; i < N; i++) send_word(32'hC0000000 + W'(i), 1'b0);
    idle(1);
    step(1'b1, 8'hD0); step(1'b1, 8'h0D); step(1'b1, 8'hF0);
    en = 1'b1;
    step(1'b1, 8'h0D);
    chk("s5_ovf", ovf, 0);
    chk("s5_cnt", fifo_cnt, N);
    idle((N + 1) * (TG + 2) + 2);
    chk("s5_count", got.size(), N + 1);
    if (got.size() == N + 1) chk("s5_last", got[N], 32'hD00DF00D);

    // Reset mid-word, then during GAP with a word still queued.
    step(1'b1, 8'h12); step(1'b1, 8'h34);
    do_reset();
    en = 1'b0;
    send_word(32'h0BADF00D, 1'b0);
    send_word(32'hFEEDFACE, 1'b0);
    en = 1'b1;
    idle(3);
    do_reset();
    got.delete(); got_cyc.delete();
    send_word(32'h5A5AA5A5, 1'b0);
    idle(6);
    chk("s6_count", got.size(), 1);
    if (got.size() == 1) chk("s6_word", got[0], 32'h5A5AA5A5);

    // Random traffic, en toggling, occasional clears and timeouts.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom % 50 == 0) en = ~en;
      clr_err = ($urandom % 40 == 0);
      if ($urandom % 100 == 0) idle(TT + 2);
      else step(($urandom % 3) != 0, 8'($urandom));
    end
    clr_err = 1'b0;
    en = 1'b1;
    idle((N + 1) * (TG + 2) + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
